// File: rtl/gate_led_pkg.sv
// Shared definitions for the debounced N-input gate LED driver:
// function-select codes and the gate evaluation function.
package gate_led_pkg;

    // Per-channel function select codes
    localparam logic [2:0] MODE_AND  = 3'd0;
    localparam logic [2:0] MODE_NAND = 3'd1;
    localparam logic [2:0] MODE_OR   = 3'd2;
    localparam logic [2:0] MODE_NOR  = 3'd3;
    localparam logic [2:0] MODE_XOR  = 3'd4;
    localparam logic [2:0] MODE_XNOR = 3'd5;
    localparam logic [2:0] MODE_BUF  = 3'd6;
    localparam logic [2:0] MODE_OFF  = 3'd7;

    // Widest switch group gate_eval can reduce; callers zero-extend into it
    localparam int GATE_MAX_W = 64;

    // Evaluate the selected function over the low 'width' bits of vec.
    // Bits at or above 'width' are ignored, so AND is not poisoned by padding.
    function automatic logic gate_eval(input logic [2:0]            mode,
                                       input logic [GATE_MAX_W-1:0] vec,
                                       input int                    width);
        logic and_r;
        logic or_r;
        logic xor_r;
        logic result;
        and_r = 1'b1;
        or_r  = 1'b0;
        xor_r = 1'b0;
        for (int i = 0; i < GATE_MAX_W; i++) begin
            if (i < width) begin
                and_r = and_r & vec[i];
                or_r  = or_r  | vec[i];
                xor_r = xor_r ^ vec[i];
            end
        end
        case (mode)
            MODE_AND:  result = and_r;
            MODE_NAND: result = ~and_r;
            MODE_OR:   result = or_r;
            MODE_NOR:  result = ~or_r;
            MODE_XOR:  result = xor_r;
            MODE_XNOR: result = ~xor_r;
            MODE_BUF:  result = vec[0];
            default:   result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/debounced_nary_gate_leds_switch_debounce.sv
// One-bit switch conditioner: two-flop synchroniser followed by a
// consecutive-cycle debounce counter. stable only follows the synchronised
// input after it has differed for DEBOUNCE_CYCLES cycles in a row.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    // Synchronise the asynchronous switch pin into clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Count consecutive disagreeing cycles; any agreement restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync_p1 == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= sync_p1;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/debounced_nary_gate_leds.sv
// CHANNELS independent gate channels. Each debounces its WIDTH switch bits,
// applies a runtime-selected N-input function and drives a registered result,
// a polarity-adjusted LED and a one-cycle change pulse.
module debounced_nary_gate_leds
    import gate_led_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int CHANNELS        = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LED_ACTIVE_LOW  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] sw,
    input  logic [3*CHANNELS-1:0]     mode,
    output logic [CHANNELS-1:0]       gate_out,
    output logic [CHANNELS-1:0]       led,
    output logic [CHANNELS-1:0]       changed
);

    localparam bit LED_LOW = (LED_ACTIVE_LOW != 0);

    logic [CHANNELS*WIDTH-1:0] stable;
    logic [CHANNELS-1:0]       gate_next;

    for (genvar b = 0; b < CHANNELS * WIDTH; b++) begin : g_db
        switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (sw[b]),
            .stable (stable[b])
        );
    end

    // Evaluate each channel's function on its debounced group and current mode
    always_comb begin
        gate_next = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            gate_next[c] = gate_eval(mode[c*3 +: 3],
                                     GATE_MAX_W'(stable[c*WIDTH +: WIDTH]),
                                     WIDTH);
        end
    end

    // Register result, LED drive and toggle pulse on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_out <= '0;
            led      <= LED_LOW ? '1 : '0;
            changed  <= '0;
        end else begin
            gate_out <= gate_next;
            led      <= LED_LOW ? ~gate_next : gate_next;
            changed  <= gate_next ^ gate_out;
        end
    end

endmodule
